// File: rtl/trap_csr_unit_if.sv
// rtl/trap_csr_unit_if.sv - CSR instruction port between the execute stage and the trap CSR unit
//
// Purpose: bundles the execute stage's CSR access signals.
//   master : execute stage (drives the request, receives read data / illegal flag)
//   slave  : trap_csr_unit
// Signals:
//   csr_en      1   CSR instruction commits this cycle
//   csr_op      2   01 RW, 10 RS, 11 RC, 00 read only
//   csr_addr    12  CSR address
//   csr_wdata   32  rs1/zimm operand
//   csr_rdata   32  combinational read of csr_addr (pre-write value)
//   csr_illegal 1   unimplemented address or write to a read-only CSR
interface trap_csr_unit_if;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (
    output csr_en, csr_op, csr_addr, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_en, csr_op, csr_addr, csr_wdata,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/trap_csr_unit.sv
// rtl/trap_csr_unit.sv - machine-mode trap CSR file with trap entry, mret and interrupt request
//
// Purpose: holds mstatus/mie/mtvec/mscratch/mepc/mcause/mip/mhartid, commits trap
//   entry and mret, serves CSR instructions and raises a registered, prioritised
//   interrupt request. Optional 64-bit mcycle/minstret counters are built when the
//   macro TRAP_CSR_COUNTERS_EN is defined; otherwise their addresses are illegal.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   csr                      CSR instruction port (trap_csr_unit_if.slave)
//   exception_i/_pc_i/_cause_i  trap taken this cycle, faulting PC, cause
//   mret_i                   mret commits this cycle
//   mret_target_o            current mepc
//   mtvec_base_o/mode_o      trap vector base and mode
//   irq_timer_i/irq_software_i/irq_external_i  level interrupt lines
//   irq_pending_o/irq_cause_o  registered interrupt request and cause
//   retire_i                 one instruction retired
module trap_csr_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  trap_csr_unit_if.slave        csr,
  input  logic                  exception_i,
  input  logic [31:0]           exception_pc_i,
  input  logic [31:0]           exception_cause_i,
  input  logic                  mret_i,
  output logic [31:0]           mret_target_o,
  output logic [31:0]           mtvec_base_o,
  output logic [1:0]            mtvec_mode_o,
  input  logic                  irq_timer_i,
  input  logic                  irq_software_i,
  input  logic                  irq_external_i,
  output logic                  irq_pending_o,
  output logic [31:0]           irq_cause_o,
  input  logic                  retire_i
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
`ifdef TRAP_CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

  localparam logic [1:0]  OP_NONE = 2'b00;
  localparam logic [1:0]  OP_RW   = 2'b01;
  localparam logic [1:0]  OP_RS   = 2'b10;

  // mie/mip implement only the machine software/timer/external bits
  localparam logic [31:0] IRQ_MASK    = 32'h0000_0888;
  localparam logic [31:0] CAUSE_M_EXT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_M_SW  = 32'h8000_0003;
  localparam logic [31:0] CAUSE_M_TMR = 32'h8000_0007;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mip_q, mip_d;
  logic        irq_pending_q, irq_pending_d;
  logic [31:0] irq_cause_q, irq_cause_d;
`ifdef TRAP_CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`else
  logic        unused_retire;
  assign unused_retire = retire_i;
`endif

  logic [31:0] mstatus_rd;
  logic [31:0] rdata;
  logic        addr_hit;
  logic        addr_ro;
  logic        write_req;
  logic        illegal;
  logic        wr_en;
  logic [31:0] wval;
  logic [31:0] irq_active;

  // MPP is hardwired to machine mode
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

  // Read decode: also classifies the address as implemented / read-only
  always_comb begin
    rdata    = 32'd0;
    addr_hit = 1'b1;
    addr_ro  = 1'b0;
    case (csr.csr_addr)
      ADDR_MSTATUS:  rdata = mstatus_rd;
      ADDR_MIE:      rdata = mie_q;
      ADDR_MTVEC:    rdata = mtvec_q;
      ADDR_MSCRATCH: rdata = mscratch_q;
      ADDR_MEPC:     rdata = mepc_q;
      ADDR_MCAUSE:   rdata = mcause_q;
      ADDR_MIP: begin
        rdata   = mip_q;
        addr_ro = 1'b1;
      end
      ADDR_MHARTID: begin
        rdata   = MHARTID;
        addr_ro = 1'b1;
      end
`ifdef TRAP_CSR_COUNTERS_EN
      ADDR_MCYCLE:    rdata = mcycle_q[31:0];
      ADDR_MCYCLEH:   rdata = mcycle_q[63:32];
      ADDR_MINSTRET:  rdata = minstret_q[31:0];
      ADDR_MINSTRETH: rdata = minstret_q[63:32];
      ADDR_CYCLE: begin
        rdata   = mcycle_q[31:0];
        addr_ro = 1'b1;
      end
      ADDR_CYCLEH: begin
        rdata   = mcycle_q[63:32];
        addr_ro = 1'b1;
      end
      ADDR_INSTRET: begin
        rdata   = minstret_q[31:0];
        addr_ro = 1'b1;
      end
      ADDR_INSTRETH: begin
        rdata   = minstret_q[63:32];
        addr_ro = 1'b1;
      end
`endif
      default: addr_hit = 1'b0;
    endcase
  end

  // RS/RC with a zero operand never writes, so it is legal even on read-only CSRs
  assign write_req = csr.csr_en &&
                     ((csr.csr_op == OP_RW) ||
                      ((csr.csr_op != OP_NONE) && (csr.csr_wdata != 32'd0)));
  assign illegal   = csr.csr_en && (!addr_hit || (write_req && addr_ro));
  // A coincident trap entry drops the CSR write
  assign wr_en     = write_req && !illegal && !exception_i;

  always_comb begin
    wval = rdata & ~csr.csr_wdata;
    if (csr.csr_op == OP_RW) begin
      wval = csr.csr_wdata;
    end else if (csr.csr_op == OP_RS) begin
      wval = rdata | csr.csr_wdata;
    end
  end

  assign irq_active = mip_q & mie_q;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mip_d          = {20'b0, irq_external_i, 3'b0, irq_timer_i, 3'b0, irq_software_i, 3'b0};

    if (exception_i) begin
      mepc_d         = exception_pc_i & ~32'h3;
      mcause_d       = exception_cause_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else begin
      if (wr_en) begin
        case (csr.csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie_d  = wval[3];
            mstatus_mpie_d = wval[7];
          end
          ADDR_MIE:      mie_d      = wval & IRQ_MASK;
          // WARL: reserved modes 2/3 keep the previous mode
          ADDR_MTVEC:    mtvec_d    = wval[1] ? {wval[31:2], mtvec_q[1:0]} : wval;
          ADDR_MSCRATCH: mscratch_d = wval;
          ADDR_MEPC:     mepc_d     = wval & ~32'h3;
          ADDR_MCAUSE:   mcause_d   = wval;
          default: ;
        endcase
      end
      // Applied after the CSR write so mret owns mstatus when both hit it
      if (mret_i) begin
        mstatus_mie_d  = mstatus_mpie_q;
        mstatus_mpie_d = 1'b1;
      end
    end
  end

  // Interrupt request is registered from already-registered mip, giving two cycles
  // from line to irq_pending_o
  always_comb begin
    irq_pending_d = mstatus_mie_q && (irq_active != 32'd0);
    irq_cause_d   = 32'd0;
    if (irq_pending_d) begin
      if (irq_active[11]) begin
        irq_cause_d = CAUSE_M_EXT;
      end else if (irq_active[3]) begin
        irq_cause_d = CAUSE_M_SW;
      end else begin
        irq_cause_d = CAUSE_M_TMR;
      end
    end
  end

`ifdef TRAP_CSR_COUNTERS_EN
  // Increment first, then let a write override one half; the hi half therefore
  // still sees the carry from the pre-write lo value
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, retire_i};
    if (wr_en) begin
      case (csr.csr_addr)
        ADDR_MCYCLE:    mcycle_d[31:0]    = wval;
        ADDR_MCYCLEH:   mcycle_d[63:32]   = wval;
        ADDR_MINSTRET:  minstret_d[31:0]  = wval;
        ADDR_MINSTRETH: minstret_d[63:32] = wval;
        default: ;
      endcase
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'd0;
      mtvec_q        <= RESET_MTVEC;
      mscratch_q     <= 32'd0;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
      mip_q          <= 32'd0;
      irq_pending_q  <= 1'b0;
      irq_cause_q    <= 32'd0;
`ifdef TRAP_CSR_COUNTERS_EN
      mcycle_q       <= 64'd0;
      minstret_q     <= 64'd0;
`endif
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mip_q          <= mip_d;
      irq_pending_q  <= irq_pending_d;
      irq_cause_q    <= irq_cause_d;
`ifdef TRAP_CSR_COUNTERS_EN
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
`endif
    end
  end

  assign csr.csr_rdata   = rdata;
  assign csr.csr_illegal = illegal;
  assign mret_target_o   = mepc_q;
  assign mtvec_base_o    = {mtvec_q[31:2], 2'b00};
  assign mtvec_mode_o    = mtvec_q[1:0];
  assign irq_pending_o   = irq_pending_q;
  assign irq_cause_o     = irq_cause_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// tb/tb_trap_csr_unit.sv - self-checking bench for trap_csr_unit
module tb_trap_csr_unit;
  localparam logic [31:0] RST_MTVEC = 32'h0000_2001;
  localparam logic [31:0] HART      = 32'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception;
  logic [31:0] exception_pc;
  logic [31:0] exception_cause;
  logic        mret;
  logic [31:0] mret_target;
  logic [31:0] mtvec_base;
  logic [1:0]  mtvec_mode;
  logic        irq_timer, irq_software, irq_external;
  logic        irq_pending;
  logic [31:0] irq_cause;
  logic        retire;

  always #5 clk = ~clk;

  trap_csr_unit_if csr_bus ();

  trap_csr_unit #(.RESET_MTVEC(RST_MTVEC), .MHARTID(HART)) dut (
    .clk               (clk),
    .rst               (rst),
    .csr               (csr_bus.slave),
    .exception_i       (exception),
    .exception_pc_i    (exception_pc),
    .exception_cause_i (exception_cause),
    .mret_i            (mret),
    .mret_target_o     (mret_target),
    .mtvec_base_o      (mtvec_base),
    .mtvec_mode_o      (mtvec_mode),
    .irq_timer_i       (irq_timer),
    .irq_software_i    (irq_software),
    .irq_external_i    (irq_external),
    .irq_pending_o     (irq_pending),
    .irq_cause_o       (irq_cause),
    .retire_i          (retire)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp_rdata;
    logic        chk_rd;
    logic        exp_ill;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: compares the CSR response mid-cycle
  always @(negedge clk) begin
    sb_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (e.chk_rd) chk({e.name, ".rdata"}, csr_bus.csr_rdata, e.exp_rdata);
      chk({e.name, ".illegal"}, {31'd0, csr_bus.csr_illegal}, {31'd0, e.exp_ill});
    end
  end

  task automatic idle();
    csr_bus.csr_en    = 1'b0;
    csr_bus.csr_op    = 2'b00;
    csr_bus.csr_addr  = 12'h000;
    csr_bus.csr_wdata = 32'd0;
    exception         = 1'b0;
    exception_pc      = 32'd0;
    exception_cause   = 32'd0;
    mret              = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drive_csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
    csr_bus.csr_en    = 1'b1;
    csr_bus.csr_op    = op;
    csr_bus.csr_addr  = addr;
    csr_bus.csr_wdata = wdata;
  endtask

  task automatic expect_csr(input string name, input logic [31:0] rd, input logic chk_rd, input logic ill);
    sb_t e;
    e.name = name; e.exp_rdata = rd; e.chk_rd = chk_rd; e.exp_ill = ill;
    sb_q.push_back(e);
  endtask

  task automatic csr_cyc(input string name, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_ill);
    drive_csr(op, addr, wdata);
    expect_csr(name, exp_rd, 1'b1, exp_ill);
    tick();
  endtask

  task automatic add(input string name, input logic [1:0] op, input logic [11:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_ill);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rd; v.exp_ill = exp_ill;
    vecs.push_back(v);
  endtask

  initial begin
    // Vector table: applied after mtvec = 0x1001
    add("mtvec_rw",      2'd1, 12'h305, 32'h0000_2000, 32'h0000_1001, 1'b0);
    add("mtvec_rd",      2'd0, 12'h305, 32'h0,         32'h0000_2000, 1'b0);
    add("mtvec_warl3",   2'd1, 12'h305, 32'h0000_3003, 32'h0000_2000, 1'b0);
    add("mtvec_rd3",     2'd0, 12'h305, 32'h0,         32'h0000_3000, 1'b0);
    add("mscratch_rw",   2'd1, 12'h340, 32'hA5A5_0000, 32'h0,         1'b0);
    add("mscratch_rs",   2'd2, 12'h340, 32'h0000_00FF, 32'hA5A5_0000, 1'b0);
    add("mscratch_rc",   2'd3, 12'h340, 32'hA500_000F, 32'hA5A5_00FF, 1'b0);
    add("mscratch_rd",   2'd0, 12'h340, 32'h0,         32'h00A5_00F0, 1'b0);
    add("mepc_rw",       2'd1, 12'h341, 32'h0000_1237, 32'h0,         1'b0);
    add("mepc_rd",       2'd0, 12'h341, 32'h0,         32'h0000_1234, 1'b0);
    add("mie_rw",        2'd1, 12'h304, 32'hFFFF_FFFF, 32'h0,         1'b0);
    add("mie_rd",        2'd0, 12'h304, 32'h0,         32'h0000_0888, 1'b0);
    add("mie_rc",        2'd3, 12'h304, 32'h0000_0080, 32'h0000_0888, 1'b0);
    add("mie_rd2",       2'd0, 12'h304, 32'h0,         32'h0000_0808, 1'b0);
    add("hartid_rw",     2'd1, 12'hF14, 32'h0,         HART,          1'b1);
    add("hartid_rs0",    2'd2, 12'hF14, 32'h0,         HART,          1'b0);
    add("hartid_rc1",    2'd3, 12'hF14, 32'h1,         HART,          1'b1);
    add("hartid_rd",     2'd0, 12'hF14, 32'h0,         HART,          1'b0);
    add("unimpl_rd",     2'd0, 12'h7C0, 32'h0,         32'h0,         1'b1);
    add("unimpl_rw",     2'd1, 12'h7C0, 32'h1234,      32'h0,         1'b1);
    add("mip_rw",        2'd1, 12'h344, 32'h1,         32'h0,         1'b1);
    add("mip_rc0",       2'd3, 12'h344, 32'h0,         32'h0,         1'b0);
    add("mcause_rw",     2'd1, 12'h342, 32'h8000_0001, 32'h0,         1'b0);
    add("mcause_rd",     2'd0, 12'h342, 32'h0,         32'h8000_0001, 1'b0);
    add("mstatus_rs",    2'd2, 12'h300, 32'h8,         32'h0000_1800, 1'b0);
    add("mstatus_rd1",   2'd0, 12'h300, 32'h0,         32'h0000_1808, 1'b0);
    add("mstatus_rc",    2'd3, 12'h300, 32'h8,         32'h0000_1808, 1'b0);
    add("mstatus_rd2",   2'd0, 12'h300, 32'h0,         32'h0000_1800, 1'b0);
    add("mstatus_rwff",  2'd1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0);
    add("mstatus_rd3",   2'd0, 12'h300, 32'h0,         32'h0000_1888, 1'b0);
    add("mstatus_rw0",   2'd1, 12'h300, 32'h0,         32'h0000_1888, 1'b0);
    add("mstatus_rd4",   2'd0, 12'h300, 32'h0,         32'h0000_1800, 1'b0);
    add("scratch_kept",  2'd0, 12'h340, 32'h0,         32'h00A5_00F0, 1'b0);
`ifndef TRAP_CSR_COUNTERS_EN
    add("mcycle_absent", 2'd1, 12'hB00, 32'h1,         32'h0,         1'b1);
    add("cycle_absent",  2'd0, 12'hC00, 32'h0,         32'h0,         1'b1);
`endif

    // Reset
    rst = 1'b1; retire = 1'b0;
    irq_timer = 1'b0; irq_software = 1'b0; irq_external = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.irq_pending", {31'd0, irq_pending}, 32'd0);
    chk("rst.irq_cause", irq_cause, 32'd0);
    chk("rst.mret_target", mret_target, 32'd0);
    chk("rst.mtvec_base", mtvec_base, 32'h0000_2000);
    chk("rst.mtvec_mode", {30'd0, mtvec_mode}, 32'd1);
    csr_cyc("rst.mtvec", 2'd0, 12'h305, 32'h0, RST_MTVEC, 1'b0);
    csr_cyc("rst.mstatus", 2'd0, 12'h300, 32'h0, 32'h0000_1800, 1'b0);

    // mtvec WARL: mode 3 keeps mode 1
    csr_cyc("mtvec_w1003", 2'd1, 12'h305, 32'h0000_1003, RST_MTVEC, 1'b0);
    chk("mtvec_base_o", mtvec_base, 32'h0000_1000);
    chk("mtvec_mode_o", {30'd0, mtvec_mode}, 32'd1);
    csr_cyc("mtvec_r1001", 2'd0, 12'h305, 32'h0, 32'h0000_1001, 1'b0);

    foreach (vecs[i]) csr_cyc(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].wdata,
                              vecs[i].exp_rdata, vecs[i].exp_ill);

    // Trap entry then mret
    csr_cyc("exc.set_mie", 2'd2, 12'h300, 32'h8, 32'h0000_1800, 1'b0);
    exception = 1'b1; exception_pc = 32'h0000_0106; exception_cause = 32'd2;
    tick();
    chk("exc.mret_target", mret_target, 32'h0000_0104);
    csr_cyc("exc.mepc", 2'd0, 12'h341, 32'h0, 32'h0000_0104, 1'b0);
    csr_cyc("exc.mcause", 2'd0, 12'h342, 32'h0, 32'd2, 1'b0);
    csr_cyc("exc.mstatus", 2'd0, 12'h300, 32'h0, 32'h0000_1880, 1'b0);
    mret = 1'b1;
    #1 chk("mret.target", mret_target, 32'h0000_0104);
    tick();
    csr_cyc("mret.mstatus", 2'd0, 12'h300, 32'h0, 32'h0000_1888, 1'b0);

    // Interrupt path: two-cycle latency and priority
    csr_cyc("irq.mie", 2'd1, 12'h304, 32'h0000_0888, 32'h0000_0808, 1'b0);
    irq_timer = 1'b1; irq_external = 1'b1;
    tick();
    chk("irq.pend_1cyc", {31'd0, irq_pending}, 32'd0);
    tick();
    chk("irq.pend_2cyc", {31'd0, irq_pending}, 32'd1);
    chk("irq.cause_ext", irq_cause, 32'h8000_000B);
    csr_cyc("irq.mip", 2'd0, 12'h344, 32'h0, 32'h0000_0880, 1'b0);
    irq_external = 1'b0;
    tick(); tick();
    chk("irq.cause_tmr", irq_cause, 32'h8000_0007);
    irq_software = 1'b1;
    tick(); tick();
    chk("irq.cause_sw", irq_cause, 32'h8000_0003);
    exception = 1'b1; exception_pc = 32'h0000_0300; exception_cause = 32'h0000_000B;
    tick();
    chk("irq.pend_exc_edge", {31'd0, irq_pending}, 32'd1);
    tick();
    chk("irq.pend_after", {31'd0, irq_pending}, 32'd0);
    irq_timer = 1'b0; irq_software = 1'b0;

    // Exception beats a coincident CSR write and mret
    csr_cyc("combo.scr_pre", 2'd1, 12'h340, 32'h0000_1111, 32'h00A5_00F0, 1'b0);
    exception = 1'b1; exception_pc = 32'h0000_0208; exception_cause = 32'd7; mret = 1'b1;
    drive_csr(2'd1, 12'h340, 32'h0000_DEAD);
    expect_csr("combo.rd", 32'h0000_1111, 1'b1, 1'b0);
    tick();
    chk("combo.mret_target", mret_target, 32'h0000_0208);
    csr_cyc("combo.mscratch", 2'd0, 12'h340, 32'h0, 32'h0000_1111, 1'b0);
    csr_cyc("combo.mcause", 2'd0, 12'h342, 32'h0, 32'd7, 1'b0);
    csr_cyc("combo.mstatus", 2'd0, 12'h300, 32'h0, 32'h0000_1800, 1'b0);

    // mret wins mstatus over a CSR write; other writes still land
    mret = 1'b1;
    csr_cyc("mretw.ms_wr", 2'd1, 12'h300, 32'h8, 32'h0000_1800, 1'b0);
    csr_cyc("mretw.ms_rd", 2'd0, 12'h300, 32'h0, 32'h0000_1880, 1'b0);
    mret = 1'b1;
    csr_cyc("mretw.scr_wr", 2'd1, 12'h340, 32'h0000_2222, 32'h0000_1111, 1'b0);
    csr_cyc("mretw.scr_rd", 2'd0, 12'h340, 32'h0, 32'h0000_2222, 1'b0);
    csr_cyc("mretw.ms_rd2", 2'd0, 12'h300, 32'h0, 32'h0000_1888, 1'b0);

    // Reset during a trap entry
    rst = 1'b1;
    exception = 1'b1; exception_pc = 32'h0000_0400; exception_cause = 32'd5;
    tick();
    rst = 1'b0;
    chk("mrst.mret_target", mret_target, 32'd0);
    chk("mrst.irq_pending", {31'd0, irq_pending}, 32'd0);
    csr_cyc("mrst.mstatus", 2'd0, 12'h300, 32'h0, 32'h0000_1800, 1'b0);
    csr_cyc("mrst.mtvec", 2'd0, 12'h305, 32'h0, RST_MTVEC, 1'b0);
    csr_cyc("mrst.mscratch", 2'd0, 12'h340, 32'h0, 32'd0, 1'b0);
    csr_cyc("mrst.mcause", 2'd0, 12'h342, 32'h0, 32'd0, 1'b0);
    csr_cyc("mrst.mie", 2'd0, 12'h304, 32'h0, 32'd0, 1'b0);

`ifdef TRAP_CSR_COUNTERS_EN
    // Preload mcycle to all ones and watch it wrap
    drive_csr(2'd1, 12'hB80, 32'hFFFF_FFFF); tick();
    drive_csr(2'd1, 12'hB00, 32'hFFFF_FFFF); tick();
    csr_cyc("cnt.hi_ones", 2'd0, 12'hB80, 32'h0, 32'hFFFF_FFFF, 1'b0);
    csr_cyc("cnt.lo_wrap", 2'd0, 12'hB00, 32'h0, 32'd0, 1'b0);
    csr_cyc("cnt.hi_wrap", 2'd0, 12'hB80, 32'h0, 32'd0, 1'b0);
    csr_cyc("cnt.cycle_mirror", 2'd0, 12'hC00, 32'h0, 32'd2, 1'b0);
    drive_csr(2'd1, 12'hB02, 32'h0); tick();
    drive_csr(2'd1, 12'hB82, 32'h0); tick();
    for (int i = 0; i < 10; i++) begin
      retire = (i % 2 == 0);
      tick();
    end
    retire = 1'b0;
    csr_cyc("cnt.minstret", 2'd0, 12'hB02, 32'h0, 32'd5, 1'b0);
    csr_cyc("cnt.instret_hi", 2'd0, 12'hC82, 32'h0, 32'd0, 1'b0);
    drive_csr(2'd1, 12'hC00, 32'h1);
    expect_csr("cnt.cycle_ro", 32'h0, 1'b0, 1'b1);
    tick();
`endif

    tick();
    chk("sb_drain", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
